alu_operand_stage: RTL and testbench

ID/EX pipeline register and operand-select stage of the 5-stage RV32I core; sits directly upstream of the ALU and feeds its `a`, `b` and 4-bit `ALUop` inputs. It latches decoded instruction fields and generates the ALU opcode from opcode/funct3/funct7[5]. It forwards results from EX/MEM and MEM/WB onto the ALU operands and detects load-use hazards, inserting a bubble when one occurs.

---
 rtl/alu_operand_stage.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ============================================================================
// Module  : alu_operand_stage
// Brief   : RV32I ID/EX register, ALU opcode decode, operand forwarding and
//           load-use hazard bubble. Optional macro: ALU_OPERAND_FWD_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_5,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic            stall,
    input  logic            flush,
    input  logic            exmem_regwrite,
    input  logic [4:0]      exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_regwrite,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic            hazard_stall,
    output logic            ex_valid,
    output logic [4:0]      ex_rd,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_branch,
    output logic [2:0]      ex_funct3,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] ex_store_data,
    output logic            ex_illegal
);

    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_opimm  = 7'b0010011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;

    localparam logic [3:0] c_alu_add  = 4'b0000;
    localparam logic [3:0] c_alu_sub  = 4'b0001;
    localparam logic [3:0] c_alu_and  = 4'b0100;
    localparam logic [3:0] c_alu_or   = 4'b0101;
    localparam logic [3:0] c_alu_xor  = 4'b0110;
    localparam logic [3:0] c_alu_sll  = 4'b1000;
    localparam logic [3:0] c_alu_srl  = 4'b1010;
    localparam logic [3:0] c_alu_sra  = 4'b1011;
    localparam logic [3:0] c_alu_slt  = 4'b1100;
    localparam logic [3:0] c_alu_sltu = 4'b1101;

    localparam logic [1:0] c_a_rs1  = 2'd0;
    localparam logic [1:0] c_a_pc   = 2'd1;
    localparam logic [1:0] c_a_zero = 2'd2;
    localparam logic [1:0] c_b_rs2  = 2'd0;
    localparam logic [1:0] c_b_imm  = 2'd1;
    localparam logic [1:0] c_b_four = 2'd2;

    localparam logic [XLEN-1:0] c_four = {{(XLEN-3){1'b0}}, 3'b100};

    logic [3:0]      w_alu_op;
    logic [1:0]      w_a_sel;
    logic [1:0]      w_b_sel;
    logic            w_regwrite;
    logic            w_memread;
    logic            w_memwrite;
    logic            w_branch;
    logic            w_illegal;

    logic [1:0]      r_a_sel;
    logic [1:0]      r_b_sel;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;

    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;

    // funct7_5 selects sub only for register-register ops; shifts always use it.
    function automatic logic [3:0] f_alu_map(input logic [2:0] f3, input logic f7,
                                             input logic is_op);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_op && f7) ? c_alu_sub : c_alu_add;
            3'b001:  op = c_alu_sll;
            3'b010:  op = c_alu_slt;
            3'b011:  op = c_alu_sltu;
            3'b100:  op = c_alu_xor;
            3'b101:  op = f7 ? c_alu_sra : c_alu_srl;
            3'b110:  op = c_alu_or;
            default: op = c_alu_and;
        endcase
        return op;
    endfunction

    always_comb begin
        w_alu_op   = c_alu_add;
        w_a_sel    = c_a_rs1;
        w_b_sel    = c_b_rs2;
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_branch   = 1'b0;
        w_illegal  = 1'b0;
        case (id_opcode)
            c_opc_op: begin
                w_alu_op   = f_alu_map(id_funct3, id_funct7_5, 1'b1);
                w_regwrite = 1'b1;
            end
            c_opc_opimm: begin
                w_alu_op   = f_alu_map(id_funct3, id_funct7_5, 1'b0);
                w_b_sel    = c_b_imm;
                w_regwrite = 1'b1;
            end
            c_opc_load: begin
                w_b_sel    = c_b_imm;
                w_memread  = 1'b1;
                w_regwrite = 1'b1;
            end
            c_opc_store: begin
                w_b_sel    = c_b_imm;
                w_memwrite = 1'b1;
            end
            c_opc_branch: begin
                w_alu_op = c_alu_sub;
                w_branch = 1'b1;
            end
            c_opc_lui: begin
                w_a_sel    = c_a_zero;
                w_b_sel    = c_b_imm;
                w_regwrite = 1'b1;
            end
            c_opc_auipc: begin
                w_a_sel    = c_a_pc;
                w_b_sel    = c_b_imm;
                w_regwrite = 1'b1;
            end
            c_opc_jal, c_opc_jalr: begin
                w_a_sel    = c_a_pc;
                w_b_sel    = c_b_four;
                w_regwrite = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

`ifdef ALU_OPERAND_FWD_EN
    always_comb begin
        w_rs1_fwd = r_rs1_data;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == r_rs1))
            w_rs1_fwd = exmem_result;
        else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == r_rs1))
            w_rs1_fwd = memwb_result;
    end

    always_comb begin
        w_rs2_fwd = r_rs2_data;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == r_rs2))
            w_rs2_fwd = exmem_result;
        else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == r_rs2))
            w_rs2_fwd = memwb_result;
    end

    assign hazard_stall = ex_valid && ex_memread && (ex_rd != 5'd0) && id_valid &&
                          ((ex_rd == id_rs1) || (ex_rd == id_rs2));
`else
    // Without bypassing, any pending writer of a source register must drain first.
    function automatic logic f_raw(input logic [4:0] rs, input logic ex_wr,
                                   input logic [4:0] ex_dst, input logic mem_wr,
                                   input logic [4:0] mem_dst, input logic wb_wr,
                                   input logic [4:0] wb_dst);
        return (rs != 5'd0) && ((ex_wr  && (ex_dst  == rs)) ||
                                (mem_wr && (mem_dst == rs)) ||
                                (wb_wr  && (wb_dst  == rs)));
    endfunction

    logic w_unused_results;
    assign w_unused_results = ^{exmem_result, memwb_result};

    assign w_rs1_fwd = r_rs1_data;
    assign w_rs2_fwd = r_rs2_data;

    assign hazard_stall = id_valid &&
        (f_raw(id_rs1, ex_valid && ex_regwrite, ex_rd, exmem_regwrite, exmem_rd,
               memwb_regwrite, memwb_rd) ||
         f_raw(id_rs2, ex_valid && ex_regwrite, ex_rd, exmem_regwrite, exmem_rd,
               memwb_regwrite, memwb_rd));
`endif

    always_comb begin
        case (r_a_sel)
            c_a_rs1: alu_a = w_rs1_fwd;
            c_a_pc:  alu_a = r_pc;
            default: alu_a = '0;
        endcase
    end

    always_comb begin
        case (r_b_sel)
            c_b_rs2:  alu_b = w_rs2_fwd;
            c_b_imm:  alu_b = r_imm;
            c_b_four: alu_b = c_four;
            default:  alu_b = '0;
        endcase
    end

    assign ex_store_data = ex_memwrite ? w_rs2_fwd : r_rs2_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_illegal  <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            alu_op      <= c_alu_add;
            r_a_sel     <= c_a_rs1;
            r_b_sel     <= c_b_rs2;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_illegal  <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
        end else if (!stall) begin
            ex_rd      <= id_rd;
            ex_funct3  <= id_funct3;
            alu_op     <= w_alu_op;
            r_a_sel    <= w_a_sel;
            r_b_sel    <= w_b_sel;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_pc       <= id_pc;
            if (hazard_stall) begin
                ex_valid    <= 1'b0;
                ex_illegal  <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                ex_memwrite <= 1'b0;
                ex_branch   <= 1'b0;
            end else begin
                ex_valid    <= id_valid && !w_illegal;
                ex_illegal  <= id_valid && w_illegal;
                ex_regwrite <= id_valid && w_regwrite && (id_rd != 5'd0);
                ex_memread  <= id_valid && w_memread;
                ex_memwrite <= id_valid && w_memwrite;
                ex_branch   <= id_valid && w_branch;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
// ============================================================================
// Module  : tb_alu_operand_stage
// Brief   : Directed and randomized self-checking bench for alu_operand_stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic        id_funct7_5;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic        stall, flush;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        hazard_stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite;
    logic        ex_branch, ex_illegal;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_op;

    alu_operand_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct3(id_funct3), .id_funct7_5(id_funct7_5), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
        .stall(stall), .flush(flush), .exmem_regwrite(exmem_regwrite),
        .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
        .memwb_result(memwb_result), .hazard_stall(hazard_stall),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
        .ex_funct3(ex_funct3), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .ex_store_data(ex_store_data), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP = 7'b0110011, OPIMM = 7'b0010011, LOAD = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011, BRANCH = 7'b1100011, LUI = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;

    typedef struct packed {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm, pc;
    } ins_t;

    typedef struct packed {
        logic        legal, rw, mr, mw, br;
        logic [3:0]  op;
        logic [31:0] a, b, sd;
    } exp_t;

    // Model of what sits in EX: 0 = just reset, 1 = bubble, 2 = an accepted instruction
    int   mode;
    ins_t ins;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
`ifdef ALU_OPERAND_FWD_EN
        if (exmem_regwrite && r != 0 && exmem_rd == r) return exmem_result;
        if (memwb_regwrite && r != 0 && memwb_rd == r) return memwb_result;
`endif
        return d;
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7, input logic is_op);
        logic [3:0] tbl [8];
        tbl = '{4'b0000, 4'b1000, 4'b1100, 4'b1101, 4'b0110, 4'b1010, 4'b0101, 4'b0100};
        if (f3 == 3'b000 && is_op && f7) return 4'b0001;
        if (f3 == 3'b101 && f7) return 4'b1011;
        return tbl[f3];
    endfunction

    function automatic exp_t decode(input ins_t i);
        exp_t e;
        e = '0;
        e.legal = 1'b1;
        case (i.opc)
            OP:     begin e.op = alu_of(i.f3, i.f7, 1'b1); e.a = fwd(i.rs1, i.d1); e.b = fwd(i.rs2, i.d2); e.rw = 1; end
            OPIMM:  begin e.op = alu_of(i.f3, i.f7, 1'b0); e.a = fwd(i.rs1, i.d1); e.b = i.imm; e.rw = 1; end
            LOAD:   begin e.a = fwd(i.rs1, i.d1); e.b = i.imm; e.mr = 1; e.rw = 1; end
            STORE:  begin e.a = fwd(i.rs1, i.d1); e.b = i.imm; e.mw = 1; e.sd = fwd(i.rs2, i.d2); end
            BRANCH: begin e.op = 4'b0001; e.a = fwd(i.rs1, i.d1); e.b = fwd(i.rs2, i.d2); e.br = 1; end
            LUI:    begin e.a = 0; e.b = i.imm; e.rw = 1; end
            AUIPC:  begin e.a = i.pc; e.b = i.imm; e.rw = 1; end
            JAL, JALR: begin e.a = i.pc; e.b = 4; e.rw = 1; end
            default: e.legal = 1'b0;
        endcase
        if (i.rd == 0) e.rw = 0;
        return e;
    endfunction

    function automatic logic exp_hazard();
        exp_t e;
        logic v, wr;
        e  = decode(ins);
        v  = (mode == 2) && e.legal;
        wr = v && e.rw;
`ifdef ALU_OPERAND_FWD_EN
        return v && e.mr && ins.rd != 0 && id_valid && (ins.rd == id_rs1 || ins.rd == id_rs2);
`else
        return id_valid && (
            (id_rs1 != 0 && ((wr && ins.rd == id_rs1) || (exmem_regwrite && exmem_rd == id_rs1) ||
                             (memwb_regwrite && memwb_rd == id_rs1))) ||
            (id_rs2 != 0 && ((wr && ins.rd == id_rs2) || (exmem_regwrite && exmem_rd == id_rs2) ||
                             (memwb_regwrite && memwb_rd == id_rs2))));
`endif
    endfunction

    task automatic check_now();
        exp_t e;
        #1;
        chk("hazard_stall", hazard_stall, exp_hazard());
        e = decode(ins);
        if (mode == 2) begin
            chk("ex_valid", ex_valid, e.legal);
            chk("ex_illegal", ex_illegal, !e.legal);
            chk("ex_regwrite", ex_regwrite, e.rw);
            chk("ex_memread", ex_memread, e.mr);
            chk("ex_memwrite", ex_memwrite, e.mw);
            chk("ex_branch", ex_branch, e.br);
            if (e.legal) begin
                chk("ex_rd", ex_rd, ins.rd);
                chk("ex_funct3", ex_funct3, ins.f3);
                chk("alu_op", alu_op, e.op);
                chk("alu_a", alu_a, e.a);
                chk("alu_b", alu_b, e.b);
                if (e.mw) chk("ex_store_data", ex_store_data, e.sd);
            end
        end else begin
            chk("bubble_ctrl", {ex_valid, ex_illegal, ex_regwrite, ex_memread, ex_memwrite, ex_branch}, 0);
            if (mode == 0) begin
                chk("rst_alu_op", alu_op, 0);
                chk("rst_alu_a", alu_a, 0);
                chk("rst_alu_b", alu_b, 0);
                chk("rst_store", ex_store_data, 0);
                chk("rst_rd_f3", {ex_rd, ex_funct3}, 0);
            end
        end
    endtask

    task automatic advance();
        logic h;
        h = exp_hazard();
        if (!rst_n) mode = 0;
        else if (flush) mode = 1;
        else if (stall) ;
        else if (h || !id_valid) mode = 1;
        else begin
            mode = 2;
            ins  = '{id_opcode, id_funct3, id_funct7_5, id_rs1, id_rs2, id_rd,
                     id_rs1_data, id_rs2_data, id_imm, id_pc};
        end
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                          input logic f7, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm);
        id_valid = v; id_opcode = opc; id_funct3 = f3; id_funct7_5 = f7;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_pc = 32'h0000_1000;
    endtask

    task automatic set_byp(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                           input logic mw, input logic [4:0] mr, input logic [31:0] md);
        exmem_regwrite = ew; exmem_rd = er; exmem_result = ed;
        memwb_regwrite = mw; memwb_rd = mr; memwb_result = md;
    endtask

    initial begin
        logic [6:0] opcs [11];
        opcs = '{OP, OPIMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, 7'h7f, 7'h00};
        ins = '0;
        mode = 0;
        rst_n = 0; stall = 0; flush = 0;
        set_id(0, OP, 0, 0, 0, 0, 0, 0, 0, 0);
        set_byp(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        check_now();

        // add x3,x1,x2 then forward x1 with both bypass stages matching
        set_id(1, OP, 3'b000, 0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 0);
        check_now(); advance();
        set_id(0, OP, 0, 0, 0, 0, 0, 0, 0, 0);
        set_byp(1, 5'd1, 32'd100, 1, 5'd1, 32'd200);
        check_now();
        chk("fwd_alu_op", alu_op, 4'b0000);
`ifdef ALU_OPERAND_FWD_EN
        chk("fwd_alu_a", alu_a, 32'd100);
`else
        chk("fwd_alu_a", alu_a, 32'd5);
`endif
        chk("fwd_alu_b", alu_b, 32'd7);
        advance();
        set_byp(0, 0, 0, 0, 0, 0);

        // srai x7, x9, 4
        set_id(1, OPIMM, 3'b101, 1, 5'd9, 5'd4, 5'd7, 32'h8000_0000, 0, 32'd4);
        check_now(); advance();
        set_id(0, OP, 0, 0, 0, 0, 0, 0, 0, 0);
        check_now();
        chk("srai_op", alu_op, 4'b1011);
        chk("srai_b", alu_b, 32'd4);
        chk("srai_rw", ex_regwrite, 1);
        advance();

        // lw x5 followed by add x6,x5,x0
        set_id(1, LOAD, 3'b010, 0, 5'd0, 5'd0, 5'd5, 0, 0, 32'h10);
        check_now(); advance();
        set_id(1, OP, 3'b000, 0, 5'd5, 5'd0, 5'd6, 32'h11, 32'h0, 0);
        check_now();
        chk("lu_hazard", hazard_stall, 1);
        advance();
        set_byp(1, 5'd5, 32'h55, 0, 0, 0);
        check_now();
        chk("lu_bubble", ex_valid, 0);
        advance();
        set_byp(0, 0, 0, 1, 5'd5, 32'h55);
        check_now(); advance();
        set_id(0, OP, 0, 0, 0, 0, 0, 0, 0, 0);
        check_now(); advance();
        set_byp(0, 0, 0, 0, 0, 0);
        check_now(); advance();

        // stall for three cycles, then stall+flush together
        set_id(1, OP, 3'b100, 0, 5'd2, 5'd3, 5'd4, 32'hA5, 32'h5A, 0);
        check_now(); advance();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            set_id(1, OPIMM, 3'b110, 0, 5'd6, 5'd0, 5'd8, $urandom, 0, $urandom);
            check_now();
            chk("stall_op", alu_op, 4'b0110);
            advance();
        end
        flush = 1;
        check_now(); advance();
        check_now();
        chk("flush_valid", ex_valid, 0);
        chk("flush_rw", ex_regwrite, 0);
        stall = 0; flush = 0;
        set_id(0, OP, 0, 0, 0, 0, 0, 0, 0, 0);
        advance();

        // x0 source never forwarded
        set_id(1, OP, 3'b000, 0, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 0);
        check_now(); advance();
        set_id(0, OP, 0, 0, 0, 0, 0, 0, 0, 0);
        set_byp(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
        check_now();
        chk("x0_alu_a", alu_a, 0);
        advance();
        set_byp(0, 0, 0, 0, 0, 0);

        // illegal opcode, then reset mid-stream
        set_id(1, 7'b1111111, 0, 0, 0, 0, 5'd9, 0, 0, 0);
        check_now(); advance();
        set_id(1, OP, 3'b111, 0, 5'd1, 5'd2, 5'd3, 32'hF0, 32'h0F, 0);
        check_now();
        chk("illegal_flag", ex_illegal, 1);
        chk("illegal_valid", ex_valid, 0);
        advance();
        rst_n = 0;
        check_now(); advance();
        rst_n = 1;
        set_id(0, OP, 0, 0, 0, 0, 0, 0, 0, 0);
        check_now();
        chk("rst_valid", ex_valid, 0);
        chk("rst_alu_a_mid", alu_a, 0);
        advance();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            set_id(($urandom_range(0, 7) != 0), opcs[$urandom_range(0, 10)],
                   3'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom, $urandom, $urandom);
            id_pc = $urandom;
            set_byp(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 63) != 0);
            check_now();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
